// File: rtl/rtc_bus_sched.sv
// rtc_bus_sched
// Shared-bus scheduler for the RTC multiplexed address/data interface.
// Four bus-mastering sub-blocks raise requests; a round-robin arbiter picks
// one and the FSM runs a full Intel-style multiplexed cycle for it: address
// phase (setup, strobe, hold), a gap, then a write or read data phase,
// finishing with a one-cycle completion pulse to the winner.
// All bus outputs are registered and decoded from the next state, so the
// pins change cleanly on the same edge the FSM changes state.

module rtc_bus_sched #(
   parameter int P = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  req,
   input  logic [3:0]  we,
   input  logic [31:0] addr_bus,
   input  logic [31:0] wdata_bus,
   output logic [3:0]  grant,
   output logic [3:0]  done,
   output logic [7:0]  rdata,
   output logic        busy,
   input  logic [7:0]  ADin,
   output logic [7:0]  ADout,
   output logic        oe,
   output logic        ad,
   output logic        cs,
   output logic        rd,
   output logic        wr
);

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_ARB      = 4'd1,
      S_A_SETUP  = 4'd2,
      S_A_STROBE = 4'd3,
      S_A_HOLD   = 4'd4,
      S_GAP      = 4'd5,
      S_D_SETUP  = 4'd6,
      S_D_STROBE = 4'd7,
      S_D_HOLD   = 4'd8,
      S_DONE     = 4'd9
   } state_t;

   state_t      r_state;
   state_t      w_next;

   logic [3:0]  r_cnt;
   logic [3:0]  w_cntNext;
   logic        w_phaseLast;

   logic [1:0]  r_ptr;
   logic [1:0]  r_owner;
   logic        r_we;
   logic [7:0]  r_addr;
   logic [7:0]  r_wdata;

   logic        w_found;
   logic [1:0]  w_winner;

   logic [1:0]  w_owner;
   logic        w_we;
   logic [7:0]  w_addr;
   logic [7:0]  w_wdata;
   logic [3:0]  w_ownerHot;

   logic [3:0]  r_grant;
   logic [3:0]  r_done;
   logic [7:0]  r_rdata;
   logic        r_busy;
   logic [7:0]  r_adout;
   logic        r_oe;
   logic        r_ad;
   logic        r_cs;
   logic        r_rd;
   logic        r_wr;

   logic [3:0]  w_grant;
   logic [3:0]  w_done;
   logic        w_busy;
   logic [7:0]  w_adout;
   logic        w_oe;
   logic        w_ad;
   logic        w_cs;
   logic        w_rd;
   logic        w_wr;

   // Strobe states are stretched to P cycles; the counter idles at zero
   // everywhere else so each strobe starts counting from a clean value.
   assign w_phaseLast = (r_cnt == 4'(P - 1));
   assign w_cntNext   = (((r_state == S_A_STROBE) || (r_state == S_D_STROBE)) && !w_phaseLast)
                        ? (r_cnt + 4'd1) : 4'd0;

   // Round-robin search starting just after the last winner, wrapping back
   // to the last winner itself so a lone requester can win repeatedly.
   always_comb begin
      logic [1:0] v_idx;
      v_idx    = 2'd0;
      w_found  = 1'b0;
      w_winner = r_ptr;
      for (int k = 1; k <= 4; k++) begin
         v_idx = r_ptr + 2'(k);
         if (!w_found && req[v_idx]) begin
            w_found  = 1'b1;
            w_winner = v_idx;
         end
      end
   end

   // While arbitrating, the transaction fields are not latched yet, so the
   // output decode for the first bus state looks straight at the winner's
   // inputs; afterwards it uses the latched copy.
   assign w_owner    = (r_state == S_ARB) ? w_winner : r_owner;
   assign w_we       = (r_state == S_ARB) ? we[w_winner] : r_we;
   assign w_addr     = (r_state == S_ARB) ? addr_bus[{w_winner, 3'b000} +: 8] : r_addr;
   assign w_wdata    = (r_state == S_ARB) ? wdata_bus[{w_winner, 3'b000} +: 8] : r_wdata;
   assign w_ownerHot = 4'b0001 << w_owner;

   // Next-state sequencing and the bus pin values that belong to that state.
   always_comb begin
      w_next  = r_state;
      w_grant = 4'b0000;
      w_done  = 4'b0000;
      w_adout = 8'h00;
      w_oe    = 1'b0;
      w_ad    = 1'b1;
      w_cs    = 1'b1;
      w_rd    = 1'b1;
      w_wr    = 1'b1;

      unique case (r_state)
         S_IDLE:     if (|req) w_next = S_ARB;
         S_ARB:      w_next = w_found ? S_A_SETUP : S_IDLE;
         S_A_SETUP:  w_next = S_A_STROBE;
         S_A_STROBE: if (w_phaseLast) w_next = S_A_HOLD;
         S_A_HOLD:   w_next = S_GAP;
         S_GAP:      w_next = S_D_SETUP;
         S_D_SETUP:  w_next = S_D_STROBE;
         S_D_STROBE: if (w_phaseLast) w_next = S_D_HOLD;
         S_D_HOLD:   w_next = S_DONE;
         S_DONE:     w_next = S_IDLE;
         default:    w_next = S_IDLE;
      endcase

      w_busy = (w_next != S_IDLE);

      case (w_next)
         S_A_SETUP, S_A_HOLD: begin
            w_grant = w_ownerHot;
            w_oe    = 1'b1;
            w_adout = w_addr;
            w_ad    = 1'b0;
         end
         S_A_STROBE: begin
            w_grant = w_ownerHot;
            w_oe    = 1'b1;
            w_adout = w_addr;
            w_ad    = 1'b0;
            w_cs    = 1'b0;
            w_wr    = 1'b0;
         end
         S_GAP: begin
            w_grant = w_ownerHot;
         end
         S_D_SETUP, S_D_HOLD: begin
            w_grant = w_ownerHot;
            if (w_we) begin
               w_oe    = 1'b1;
               w_adout = w_wdata;
            end
         end
         S_D_STROBE: begin
            w_grant = w_ownerHot;
            w_cs    = 1'b0;
            if (w_we) begin
               w_oe    = 1'b1;
               w_adout = w_wdata;
               w_wr    = 1'b0;
            end else begin
               w_rd    = 1'b0;
            end
         end
         S_DONE: begin
            w_grant = w_ownerHot;
            w_done  = w_ownerHot;
         end
         default: begin
         end
      endcase
   end

   // State, phase counter and registered bus pins; reset aborts any cycle
   // in flight and parks every strobe inactive.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_grant <= 4'b0000;
         r_done  <= 4'b0000;
         r_busy  <= 1'b0;
         r_adout <= 8'h00;
         r_oe    <= 1'b0;
         r_ad    <= 1'b1;
         r_cs    <= 1'b1;
         r_rd    <= 1'b1;
         r_wr    <= 1'b1;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cntNext;
         r_grant <= w_grant;
         r_done  <= w_done;
         r_busy  <= w_busy;
         r_adout <= w_adout;
         r_oe    <= w_oe;
         r_ad    <= w_ad;
         r_cs    <= w_cs;
         r_rd    <= w_rd;
         r_wr    <= w_wr;
      end
   end

   // Capture the winner's transaction at arbitration so requesters may drop
   // or change their inputs once the cycle is under way.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr   <= 2'd3;
         r_owner <= 2'd0;
         r_we    <= 1'b0;
         r_addr  <= 8'h00;
         r_wdata <= 8'h00;
      end else if ((r_state == S_ARB) && w_found) begin
         r_ptr   <= w_winner;
         r_owner <= w_winner;
         r_we    <= we[w_winner];
         r_addr  <= addr_bus[{w_winner, 3'b000} +: 8];
         r_wdata <= wdata_bus[{w_winner, 3'b000} +: 8];
      end
   end

   // Read data is sampled from the pins as the read strobe ends and held
   // until the next read completes.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdata <= 8'h00;
      end else if ((r_state == S_D_STROBE) && w_phaseLast && !r_we) begin
         r_rdata <= ADin;
      end
   end

   assign grant = r_grant;
   assign done  = r_done;
   assign rdata = r_rdata;
   assign busy  = r_busy;
   assign ADout = r_adout;
   assign oe    = r_oe;
   assign ad    = r_ad;
   assign cs    = r_cs;
   assign rd    = r_rd;
   assign wr    = r_wr;

endmodule
